// File: rtl/cic_ctrl_pkg.sv
// Shared constants for the CicFilter run-time controller.
//   - state encoding (IDLE/FLUSH/SETTLE/RUN)
//   - legal decimation-factor range
//   - dropped-sample counter width
package cic_ctrl_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFlush  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StRun    = 2'd3;

  localparam int unsigned MinFactor    = 2;
  localparam int unsigned DropCntWidth = 16;

  // Largest factor representable in a counter of the given width.
  function automatic int unsigned max_factor(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/cic_cfg_check.sv
// Combinational decimation-factor validity check.
// Ports:
//   i_factor - requested decimation factor
//   o_valid  - high when MinFactor <= i_factor <= max_factor(DecimCntWidth)
module cic_cfg_check
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned DecimCntWidth = 7
) (
  input  logic [DecimCntWidth-1:0] i_factor,
  output logic                     o_valid
);

  logic [31:0] w_factor;

  always_comb begin
    w_factor = 32'(i_factor);
    o_valid  = (w_factor >= MinFactor) && (w_factor <= max_factor(DecimCntWidth));
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Run-time controller for one CicFilter decimator. Accepts factor changes over a
// valid/ready handshake, restarts the filter (flush + settle) on each change and
// suppresses the filter's start-up transient outputs.
// Ports:
//   Clk_i, Rst_i (async, active-low)   - clock / reset
//   Enable_i                           - run enable
//   CfgFactor_i/CfgValid_i/CfgReady_o  - factor request handshake
//   CfgError_o                         - one-cycle pulse on rejected request
//   Data_i/DataNd_i                    - input samples
//   FiltRst_o/FiltDecimFactor_o/FiltData_o/FiltDataNd_o - drive the CicFilter
//   FiltData_i/FiltDataValid_i         - CicFilter outputs
//   Data_o/DataValid_o                 - gated decimated output
//   State_o                            - current state
//   DropCnt_o                          - saturating dropped-sample count
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned M             = 1,
  parameter int unsigned InDataWidth   = 14,
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned DecimCntWidth = 7,
  parameter int unsigned DefaultFactor = 5,
  parameter int unsigned FlushCycles   = 4,
  parameter int unsigned SettleOutputs = N * M
) (
  input  logic                            Clk_i,
  input  logic                            Rst_i,
  input  logic                            Enable_i,
  input  logic        [DecimCntWidth-1:0] CfgFactor_i,
  input  logic                            CfgValid_i,
  output logic                            CfgReady_o,
  output logic                            CfgError_o,
  input  logic signed [InDataWidth-1:0]   Data_i,
  input  logic                            DataNd_i,
  output logic                            FiltRst_o,
  output logic        [DecimCntWidth-1:0] FiltDecimFactor_o,
  output logic signed [InDataWidth-1:0]   FiltData_o,
  output logic                            FiltDataNd_o,
  input  logic signed [OutDataWidth-1:0]  FiltData_i,
  input  logic                            FiltDataValid_i,
  output logic signed [OutDataWidth-1:0]  Data_o,
  output logic                            DataValid_o,
  output logic        [1:0]               State_o,
  output logic        [DropCntWidth-1:0]  DropCnt_o
);

  localparam int unsigned FlushW  = $clog2(FlushCycles + 1);
  localparam int unsigned SettleW = $clog2(SettleOutputs + 2);

  logic [1:0]                r_state, w_state_next;
  logic [FlushW-1:0]         r_flush_cnt, w_flush_cnt_next;
  logic [SettleW-1:0]        r_settle_cnt, w_settle_cnt_next;
  logic [DecimCntWidth-1:0]  r_factor;
  logic                      r_filt_rst, r_cfg_ready, r_cfg_err, r_filt_nd, r_data_valid;
  logic [InDataWidth-1:0]    r_filt_data;
  logic [OutDataWidth-1:0]   r_data;
  logic [DropCntWidth-1:0]   r_drop;

  logic w_factor_ok, w_accept, w_valid_accept, w_fwd_in, w_fwd_out, w_drop;

  cic_cfg_check #(
    .DecimCntWidth(DecimCntWidth)
  ) u_cfg_check (
    .i_factor(CfgFactor_i),
    .o_valid (w_factor_ok)
  );

  always_comb begin
    w_accept       = CfgValid_i & r_cfg_ready;
    w_valid_accept = w_accept & w_factor_ok;
    // A strobe arriving in the RUN->FLUSH transition cycle is dropped, not forwarded.
    w_fwd_in  = DataNd_i & ((r_state == StSettle) | ((r_state == StRun) & ~w_valid_accept));
    w_drop    = DataNd_i & ~w_fwd_in;
    w_fwd_out = FiltDataValid_i & (r_state == StRun);
  end

  always_comb begin
    w_state_next      = r_state;
    w_flush_cnt_next  = '0;
    w_settle_cnt_next = '0;
    if (!Enable_i) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          // A factor update while idle holds IDLE for that cycle.
          if (!w_valid_accept) w_state_next = StFlush;
        end
        StFlush: begin
          if (r_flush_cnt == FlushW'(FlushCycles - 1)) begin
            w_state_next = (SettleOutputs == 0) ? StRun : StSettle;
          end else begin
            w_flush_cnt_next = r_flush_cnt + 1'b1;
          end
        end
        StSettle: begin
          w_settle_cnt_next = r_settle_cnt;
          if (FiltDataValid_i) begin
            if (r_settle_cnt == SettleW'(SettleOutputs - 1)) begin
              w_state_next      = StRun;
              w_settle_cnt_next = '0;
            end else begin
              w_settle_cnt_next = r_settle_cnt + 1'b1;
            end
          end
        end
        StRun: begin
          if (w_valid_accept) w_state_next = StFlush;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      r_state      <= StIdle;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
      r_factor     <= DecimCntWidth'(DefaultFactor);
      r_filt_rst   <= 1'b1;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
      r_filt_nd    <= 1'b0;
      r_filt_data  <= '0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_flush_cnt  <= w_flush_cnt_next;
      r_settle_cnt <= w_settle_cnt_next;
      // Factor only changes in IDLE/RUN accepts; both lead to FiltRst_o high next cycle.
      if (w_valid_accept) r_factor <= CfgFactor_i;
      r_filt_rst   <= (w_state_next == StIdle) | (w_state_next == StFlush);
      r_cfg_ready  <= (w_state_next == StIdle) | (w_state_next == StRun);
      r_cfg_err    <= w_accept & ~w_factor_ok;
      r_filt_nd    <= w_fwd_in;
      if (w_fwd_in) r_filt_data <= Data_i;
      r_data_valid <= w_fwd_out;
      if (w_fwd_out) r_data <= FiltData_i;
      if (w_drop && (r_drop != {DropCntWidth{1'b1}})) r_drop <= r_drop + 1'b1;
    end
  end

  assign State_o           = r_state;
  assign FiltRst_o         = r_filt_rst;
  assign CfgReady_o        = r_cfg_ready;
  assign CfgError_o        = r_cfg_err;
  assign FiltDecimFactor_o = r_factor;
  assign FiltDataNd_o      = r_filt_nd;
  assign FiltData_o        = r_filt_data;
  assign DataValid_o       = r_data_valid;
  assign Data_o            = r_data;
  assign DropCnt_o         = r_drop;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with a behavioural CicFilter stand-in.
// The stand-in emits one output every FiltDecimFactor_o forwarded strobes and
// pushes every output past the settle transient onto a scoreboard queue.
module tb_cic_decim_ctrl;

  logic               Clk_i = 1'b0;
  logic               Rst_i;
  logic               Enable_i;
  logic        [6:0]  CfgFactor_i;
  logic               CfgValid_i;
  logic               CfgReady_o;
  logic               CfgError_o;
  logic signed [13:0] Data_i;
  logic               DataNd_i;
  logic               FiltRst_o;
  logic        [6:0]  FiltDecimFactor_o;
  logic signed [13:0] FiltData_o;
  logic               FiltDataNd_o;
  logic signed [31:0] FiltData_i = '0;
  logic               FiltDataValid_i = 1'b0;
  logic signed [31:0] Data_o;
  logic               DataValid_o;
  logic        [1:0]  State_o;
  logic        [15:0] DropCnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  cic_decim_ctrl dut (
    .Clk_i            (Clk_i),
    .Rst_i            (Rst_i),
    .Enable_i         (Enable_i),
    .CfgFactor_i      (CfgFactor_i),
    .CfgValid_i       (CfgValid_i),
    .CfgReady_o       (CfgReady_o),
    .CfgError_o       (CfgError_o),
    .Data_i           (Data_i),
    .DataNd_i         (DataNd_i),
    .FiltRst_o        (FiltRst_o),
    .FiltDecimFactor_o(FiltDecimFactor_o),
    .FiltData_o       (FiltData_o),
    .FiltDataNd_o     (FiltDataNd_o),
    .FiltData_i       (FiltData_i),
    .FiltDataValid_i  (FiltDataValid_i),
    .Data_o           (Data_o),
    .DataValid_o      (DataValid_o),
    .State_o          (State_o),
    .DropCnt_o        (DropCnt_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Filter stand-in: 4 settle outputs (N*M) are transient; later ones are expected.
  int          st_cnt  = 0;
  logic [15:0] st_nout = '0;
  logic [15:0] st_tot  = '0;
  always @(posedge Clk_i) begin
    FiltDataValid_i <= 1'b0;
    if (FiltRst_o) begin
      st_cnt  <= 0;
      st_nout <= '0;
    end else if (FiltDataNd_o) begin
      if (st_cnt == int'(FiltDecimFactor_o) - 1) begin
        st_cnt          <= 0;
        FiltDataValid_i <= 1'b1;
        FiltData_i      <= {st_tot, st_nout};
        if (st_nout >= 16'd4) sb.push_back({st_tot, st_nout});
        st_nout <= st_nout + 16'd1;
        st_tot  <= st_tot + 16'd1;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every forwarded output must match the oldest expected one.
  always @(negedge Clk_i) begin
    if (Rst_i === 1'b1 && DataValid_o === 1'b1) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(DataValid_o), 32'd0);
      else check("sb_data", Data_o, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
    Data_i = Data_i + 14'sd37;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int bound);
    int n = 0;
    while (State_o !== st && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(State_o), 32'(st));
  endtask

  task automatic period(input string tag, input int exp, input int bound);
    int n = 0;
    int p = 0;
    while (DataValid_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_first"}, 32'(DataValid_o), 32'd1);
    tick();
    p = 1;
    while (DataValid_o !== 1'b1 && p < bound) begin
      tick();
      p++;
    end
    check(tag, p, exp);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_state"},   32'(State_o),           32'd0);
    check({pfx, "_filtrst"}, 32'(FiltRst_o),         32'd1);
    check({pfx, "_factor"},  32'(FiltDecimFactor_o), 32'd5);
    check({pfx, "_ready"},   32'(CfgReady_o),        32'd1);
    check({pfx, "_err"},     32'(CfgError_o),        32'd0);
    check({pfx, "_filtnd"},  32'(FiltDataNd_o),      32'd0);
    check({pfx, "_dvalid"},  32'(DataValid_o),       32'd0);
    check({pfx, "_data"},    Data_o,                 32'd0);
    check({pfx, "_filtdat"}, 32'(FiltData_o),        32'd0);
    check({pfx, "_drop"},    32'(DropCnt_o),         32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    int disc;
    int nv;
    logic [15:0] d0;
    logic [6:0] bad[2];
    bad[0] = 7'd0;
    bad[1] = 7'd1;

    Rst_i = 1'b0; Enable_i = 1'b0; CfgValid_i = 1'b0; CfgFactor_i = '0;
    DataNd_i = 1'b0; Data_i = '0;
    repeat (3) tick();
    check_reset("rst0");

    // Start-up with default factor 5, a strobe every cycle.
    Rst_i = 1'b1;
    tick();
    Enable_i = 1'b1;
    DataNd_i = 1'b1;
    tick();
    nf = 0;
    while (State_o === 2'd1 && nf < 20) begin
      if (FiltRst_o !== 1'b1) nf = 100;
      nf++;
      tick();
    end
    check("flush_len0", nf, 4);
    check("settle0_state", 32'(State_o), 32'd2);
    check("settle0_filtrst", 32'(FiltRst_o), 32'd0);
    check("settle0_ready", 32'(CfgReady_o), 32'd0);
    check("drop_startup", 32'(DropCnt_o), 32'd5);
    disc = 0;
    nv = 0;
    while (State_o === 2'd2 && nv < 100) begin
      if (FiltDataValid_i === 1'b1) disc++;
      nv++;
      tick();
    end
    check("settle0_discards", disc, 4);
    check("run0_state", 32'(State_o), 32'd3);
    check("run0_ready", 32'(CfgReady_o), 32'd1);
    period("period5", 5, 50);

    // Restart to factor 10 from RUN.
    d0 = DropCnt_o;
    CfgFactor_i = 7'd10;
    CfgValid_i = 1'b1;
    tick();
    CfgValid_i = 1'b0;
    check("r10_ready", 32'(CfgReady_o), 32'd0);
    check("r10_factor", 32'(FiltDecimFactor_o), 32'd10);
    check("r10_filtrst", 32'(FiltRst_o), 32'd1);
    check("r10_state", 32'(State_o), 32'd1);
    nf = 0;
    while (State_o === 2'd1 && nf < 20) begin
      if (FiltRst_o !== 1'b1) nf = 100;
      nf++;
      tick();
    end
    check("flush_len10", nf, 4);
    check("r10_drop", 32'(DropCnt_o), 32'(d0 + 16'd5));
    check("r10_settle", 32'(State_o), 32'd2);
    sb.delete();
    disc = 0;
    nv = 0;
    while (State_o === 2'd2 && nv < 200) begin
      if (FiltDataValid_i === 1'b1) disc++;
      nv++;
      tick();
    end
    check("settle10_discards", disc, 4);
    check("r10_run", 32'(State_o), 32'd3);
    period("period10", 10, 50);

    // Out-of-range factors are rejected with a one-cycle error pulse.
    for (int i = 0; i < 2; i++) begin
      CfgFactor_i = bad[i];
      CfgValid_i = 1'b1;
      tick();
      CfgValid_i = 1'b0;
      check($sformatf("bad%0d_err", i), 32'(CfgError_o), 32'd1);
      check($sformatf("bad%0d_factor", i), 32'(FiltDecimFactor_o), 32'd10);
      check($sformatf("bad%0d_state", i), 32'(State_o), 32'd3);
      tick();
      check($sformatf("bad%0d_errclr", i), 32'(CfgError_o), 32'd0);
    end

    // Largest factor is legal.
    CfgFactor_i = 7'd127;
    CfgValid_i = 1'b1;
    tick();
    CfgValid_i = 1'b0;
    check("r127_err", 32'(CfgError_o), 32'd0);
    check("r127_factor", 32'(FiltDecimFactor_o), 32'd127);
    check("r127_state", 32'(State_o), 32'd1);
    wait_state("r127_settle", 2'd2, 10);
    sb.delete();
    wait_state("r127_run", 2'd3, 700);
    period("period127", 127, 300);

    // Disable in the middle of SETTLE.
    CfgFactor_i = 7'd3;
    CfgValid_i = 1'b1;
    tick();
    CfgValid_i = 1'b0;
    wait_state("r3_settle", 2'd2, 10);
    sb.delete();
    tick();
    tick();
    check("r3_still_settle", 32'(State_o), 32'd2);
    Enable_i = 1'b0;
    tick();
    check("dis_state", 32'(State_o), 32'd0);
    check("dis_filtrst", 32'(FiltRst_o), 32'd1);
    nv = 0;
    repeat (20) begin
      tick();
      if (DataValid_o === 1'b1) nv++;
    end
    check("dis_no_valid", nv, 0);
    Enable_i = 1'b1;
    wait_state("r3b_settle", 2'd2, 10);
    sb.delete();
    wait_state("r3b_run", 2'd3, 100);
    check("r3b_factor", 32'(FiltDecimFactor_o), 32'd3);

    // Valid request in the same cycle Enable_i falls.
    CfgFactor_i = 7'd7;
    CfgValid_i = 1'b1;
    Enable_i = 1'b0;
    tick();
    CfgValid_i = 1'b0;
    check("same_state", 32'(State_o), 32'd0);
    check("same_factor", 32'(FiltDecimFactor_o), 32'd7);
    tick();
    tick();
    Enable_i = 1'b1;
    wait_state("r7_settle", 2'd2, 10);
    sb.delete();
    wait_state("r7_run", 2'd3, 100);
    period("period7", 7, 50);

    // Asynchronous reset in RUN, then drop-counter saturation in IDLE.
    #2;
    Rst_i = 1'b0;
    #1;
    check_reset("rst1");
    Enable_i = 1'b0;
    DataNd_i = 1'b1;
    tick();
    Rst_i = 1'b1;
    sb.delete();
    repeat (65534) tick();
    check("drop_fffe", 32'(DropCnt_o), 32'h0000_fffe);
    repeat (70000 - 65534) tick();
    check("drop_sat", 32'(DropCnt_o), 32'h0000_ffff);
    check("sat_state", 32'(State_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Run-time controller for the CicFilter decimator. It accepts decimation-factor changes over a valid/ready handshake and validates them. Each change is applied by flushing and restarting the filter, and the filter's start-up transient outputs are discarded. Sits between the configuration/register interface and one CicFilter instance; it owns the filter's reset, factor and sample-strobe inputs and gates its outputs.

## Interface
Parameters:
- N, 4, CIC stage count; sets settle length.
- M, 1, differential delay.
- InDataWidth, 14, input sample width.
- OutDataWidth, 32, filter output width.
- DecimCntWidth, 7, factor width.
- DefaultFactor, 5, factor loaded at reset.
- FlushCycles, 4, cycles FiltRst_o is held per restart (≥1).
- SettleOutputs, N*M, filter outputs discarded after restart.

Ports:
- Clk_i, in, 1, clock.
- Rst_i, in, 1, asynchronous active-low reset.
- Enable_i, in, 1, run enable.
- CfgFactor_i, in, DecimCntWidth, requested decimation factor.
- CfgValid_i, in, 1, request valid.
- CfgReady_o, out, 1, request may be accepted.
- CfgError_o, out, 1, one-cycle pulse: request rejected.
- Data_i, in, InDataWidth signed, input sample.
- DataNd_i, in, 1, input sample strobe.
- FiltRst_o, out, 1, active-high reset to CicFilter Rst_i.
- FiltDecimFactor_o, out, DecimCntWidth, to CicFilter DecimFactor_i.
- FiltData_o, out, InDataWidth signed, to CicFilter Data_i.
- FiltDataNd_o, out, 1, to CicFilter DataNd_i.
- FiltData_i, in, OutDataWidth signed, from CicFilter Data_o.
- FiltDataValid_i, in, 1, from CicFilter DataValid_o.
- Data_o, out, OutDataWidth signed, decimated output.
- DataValid_o, out, 1, output strobe.
- State_o, out, 2, current state.
- DropCnt_o, out, 16, saturating count of dropped input samples.

## Operation
- States: IDLE=0, FLUSH=1, SETTLE=2, RUN=3.
- IDLE: FiltRst_o=1, no forwarding. Moves to FLUSH when Enable_i=1.
- FLUSH: FiltRst_o=1 for exactly FlushCycles cycles, then moves to SETTLE. Input strobes are dropped and counted.
- SETTLE: FiltRst_o=0. DataNd_i is forwarded. The first SettleOutputs FiltDataValid_i pulses are discarded. The cycle that discards the last one moves to RUN.
- RUN: inputs and outputs are forwarded.
- Enable_i=0 in any state moves to IDLE on the next edge. This has priority over all other transitions.
- CfgReady_o=1 only in IDLE and RUN. A request is accepted when CfgValid_i & CfgReady_o.
- Validity: factor is valid only if 2 ≤ CfgFactor_i ≤ 2^DecimCntWidth−1.
  - Valid accept: factor register updates. In RUN the next state is FLUSH; in IDLE the state stays IDLE.
  - Invalid accept: CfgError_o pulses one cycle later. Factor and state are unchanged.
- An accept in the same cycle as Enable_i falling latches the factor and the block goes to IDLE.
- An input strobe in the RUN→FLUSH transition cycle is dropped and counted.
- DropCnt_o increments per DataNd_i seen in IDLE or FLUSH and saturates at 0xFFFF. It is cleared only by reset.

## Timing
- Reset values:
  - State_o = IDLE, FiltRst_o = 1, FiltDecimFactor_o = DefaultFactor.
  - CfgReady_o = 1, CfgError_o = 0, FiltDataNd_o = 0, DataValid_o = 0.
  - Data_o = 0, FiltData_o = 0, DropCnt_o = 0.
- All outputs are registered.
- Input forwarding: Data_i/DataNd_i at edge k appear on FiltData_o/FiltDataNd_o at k+1.
- Output forwarding: FiltData_i/FiltDataValid_i at edge k appear on Data_o/DataValid_o at k+1.
- Restart from RUN, accept at edge k:
  - From k+1: FiltDecimFactor_o holds the new factor, FiltRst_o is high, CfgReady_o is low.
  - FiltRst_o stays high through k+FlushCycles.
  - SETTLE begins at k+FlushCycles+1.
- FiltDecimFactor_o never changes while FiltRst_o=0.

## Structure
- Package cic_ctrl_pkg holds:
  - state encoding constants;
  - factor range limits MinFactor=2 and MaxFactor function of DecimCntWidth;
  - the DropCnt_o width constant.
- One natural sub-module: cic_cfg_check. It is combinational and flags whether a factor is valid; it is shared with future register-bank checks.
- Flush and settle counters live in the top level.

## Test plan
- Reset, Enable_i=1, tone input at DataNd_i=1 every cycle, default factor 5:
  - FiltRst_o high for 4 cycles;
  - the first 4 filter outputs are suppressed;
  - outputs then appear every 5th cycle.
- In RUN, request factor 10:
  - CfgReady_o drops next cycle;
  - FiltDecimFactor_o=10 and FiltRst_o=1 for 4 cycles, then SETTLE, 4 discards, then RUN;
  - DropCnt_o increases by 5 (transition cycle plus 4 FLUSH cycles).
- Request factors 0, 1 and 127:
  - CfgError_o pulses for 0 and 1 with the factor unchanged;
  - 127 is accepted.
- Enable_i deasserted mid-SETTLE: IDLE on the next edge, FiltRst_o=1, and no DataValid_o afterwards.
- Valid request and Enable_i fall in the same cycle:
  - state goes to IDLE with the factor latched;
  - re-enabling restarts with the new factor.
- Rst_i asserted mid-RUN: all outputs immediately take reset values and DropCnt_o=0. Hold DataNd_i in IDLE for 70000 cycles: DropCnt_o saturates at 0xFFFF.
